muladd_pipe: RTL and testbench

Parametrised, pipelined multiply-accumulate BEL for the DSP tile and the next generation of the fixed 8x8+20 multiply-add. It adds configurable operand widths, per-operand signedness, a valid-tracked pipeline, an accumulate-restart beat, saturating arithmetic and a sticky overflow flag. It sits behind the tile switch matrix like the existing multiply-add BEL and is configured by global ConfigBits that stay static while the block runs.

---
 rtl/muladd_pkg.sv | 43 ++++
 rtl/muladd_sat_add.sv | 57 +++++
 rtl/muladd_pipe.sv | 225 ++++++++++++++++++++++
 tb/tb_muladd_pipe.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/muladd_pkg.sv
// ----------------------------------------------------------------------------
// muladd_pkg
//   Shared constants and helpers for the muladd_pipe multiply-accumulate BEL.
//   - ConfigBits bit positions (CFG_*), ConfigBits width (NO_CONFIG_BITS)
//   - operand width limits used by the elaboration-time parameter checks
//   - cfg_t: decoded view of ConfigBits, and decode_cfg() to build it
// ----------------------------------------------------------------------------
package muladd_pkg;

    localparam int NO_CONFIG_BITS = 6;

    localparam int CFG_IN_REG = 0;
    localparam int CFG_SIGN_A = 1;
    localparam int CFG_SIGN_B = 2;
    localparam int CFG_ACC    = 3;
    localparam int CFG_SAT    = 4;
    localparam int CFG_ACCOUT = 5;

    // Legal operand widths; the accumulator must hold a full-width product.
    localparam int MIN_OP_WIDTH = 2;
    localparam int MAX_OP_WIDTH = 18;

    typedef struct packed {
        logic in_reg;
        logic sign_a;
        logic sign_b;
        logic acc;
        logic sat;
        logic accout;
    } cfg_t;

    function automatic cfg_t decode_cfg(input logic [NO_CONFIG_BITS-1:0] bits);
        cfg_t c;
        c.in_reg = bits[CFG_IN_REG];
        c.sign_a = bits[CFG_SIGN_A];
        c.sign_b = bits[CFG_SIGN_B];
        c.acc    = bits[CFG_ACC];
        c.sat    = bits[CFG_SAT];
        c.accout = bits[CFG_ACCOUT];
        return c;
    endfunction

endpackage

// File: rtl/muladd_sat_add.sv
// ----------------------------------------------------------------------------
// muladd_sat_add
//   Combinational W-bit add evaluated at W+1 bits with overflow detection and
//   optional clamping.
//   Ports:
//     a_i, b_i      W-bit operands (two's complement when signed_i=1)
//     signed_i      1: operands/result signed, 0: unsigned
//     sat_i         1: clamp on overflow, 0: wrap
//     sum_o         W-bit result (clamped or wrapped)
//     ovf_o         result fell outside the W-bit range of the chosen mode
// ----------------------------------------------------------------------------
module muladd_sat_add #(
    parameter int W = 20
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         signed_i,
    input  logic         sat_i,
    output logic [W-1:0] sum_o,
    output logic         ovf_o
);

    logic [W:0]   a_x;
    logic [W:0]   b_x;
    logic [W:0]   s_x;
    logic [W-1:0] max_s;
    logic [W-1:0] min_s;

    always_comb begin
        max_s = {1'b0, {(W-1){1'b1}}};
        min_s = {1'b1, {(W-1){1'b0}}};

        a_x = {signed_i & a_i[W-1], a_i};
        b_x = {signed_i & b_i[W-1], b_i};
        s_x = a_x + b_x;

        // Signed: the extra bit disagrees with the W-bit sign bit.
        // Unsigned: both operands are non-negative, so only a carry-out
        // can leave the range.
        if (signed_i) begin
            ovf_o = s_x[W] ^ s_x[W-1];
        end else begin
            ovf_o = s_x[W];
        end

        sum_o = s_x[W-1:0];
        if (sat_i && ovf_o) begin
            if (signed_i) begin
                // The W+1-bit sign is the true sign of the sum.
                sum_o = s_x[W] ? min_s : max_s;
            end else begin
                sum_o = '1;
            end
        end
    end

endmodule

// File: rtl/muladd_pipe.sv
// ----------------------------------------------------------------------------
// muladd_pipe
//   Pipelined multiply-accumulate BEL: Q = sat(A*B + C) or a running
//   accumulation sat(A*B + ACC), with a valid-tracked pipeline, an
//   accumulate-restart beat and a sticky overflow flag.
//
//   Handshake: in_valid qualifies A/B/C/acc_clr for one beat per cycle;
//   out_valid qualifies Q for one cycle. There is no backpressure: every
//   beat accepted produces exactly one out_valid beat unless clr_n drops
//   while it is in flight.
//
//   Ports:
//     UserCLK     clock
//     clr_n       synchronous active-low clear of every register
//     A, B        operands (A_WIDTH / B_WIDTH bits)
//     C           addend, or accumulation seed on an acc_clr beat
//     in_valid    beat qualifier
//     acc_clr     restart accumulation with this beat
//     Q           result (C_WIDTH bits)
//     out_valid   Q holds a beat result
//     ovf         sticky overflow
//     ConfigBits  static configuration: IN_REG, SIGN_A, SIGN_B, ACC, SAT, ACCOUT
//
//   Pipeline: [stage 0 optional input regs] -> stage 1 (P, C1, v1, clr1)
//             -> stage 2 (ACC, v2, ovf). Q/out_valid come from stage 1
//             (combinational sum) or stage 2 (ACC) depending on ACCOUT.
// ----------------------------------------------------------------------------
(* FABulous, BelMap, IN_REG=0, SIGN_A=1, SIGN_B=2, ACC=3, SAT=4, ACCOUT=5 *)
module muladd_pipe #(
    parameter int A_WIDTH      = 8,
    parameter int B_WIDTH      = 8,
    parameter int C_WIDTH      = 20,
    parameter int NoConfigBits = 6
) (
    (* FABulous, EXTERNAL, SHARED_PORT *)
    input  logic                    UserCLK,
    input  logic                    clr_n,
    input  logic [A_WIDTH-1:0]      A,
    input  logic [B_WIDTH-1:0]      B,
    input  logic [C_WIDTH-1:0]      C,
    input  logic                    in_valid,
    input  logic                    acc_clr,
    output logic [C_WIDTH-1:0]      Q,
    output logic                    out_valid,
    output logic                    ovf,
    (* FABulous, GLOBAL *)
    input  logic [NoConfigBits-1:0] ConfigBits
);

    import muladd_pkg::*;

    localparam int P_W = A_WIDTH + B_WIDTH;

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if (A_WIDTH < MIN_OP_WIDTH || A_WIDTH > MAX_OP_WIDTH) begin : g_bad_a_width
        $error("muladd_pipe: A_WIDTH out of range");
    end
    if (B_WIDTH < MIN_OP_WIDTH || B_WIDTH > MAX_OP_WIDTH) begin : g_bad_b_width
        $error("muladd_pipe: B_WIDTH out of range");
    end
    if (C_WIDTH < P_W) begin : g_bad_c_width
        $error("muladd_pipe: C_WIDTH must be at least A_WIDTH+B_WIDTH");
    end
    if (NoConfigBits != NO_CONFIG_BITS) begin : g_bad_cfg_width
        $error("muladd_pipe: NoConfigBits must be 6");
    end

    cfg_t cfg;
    assign cfg = decode_cfg(ConfigBits);

    // Either operand signed puts the whole datapath in signed mode.
    logic signed_mode;
    assign signed_mode = cfg.sign_a | cfg.sign_b;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [A_WIDTH-1:0] a0_q,   a0_d;
    logic [B_WIDTH-1:0] b0_q,   b0_d;
    logic [C_WIDTH-1:0] c0_q,   c0_d;
    logic               v0_q,   v0_d;
    logic               clr0_q, clr0_d;

    logic [P_W-1:0]     p1_q,   p1_d;
    logic [C_WIDTH-1:0] c1_q,   c1_d;
    logic               v1_q,   v1_d;
    logic               clr1_q, clr1_d;

    logic [C_WIDTH-1:0] acc_q,  acc_d;
    logic               v2_q,   v2_d;
    logic               ovf_q,  ovf_d;

    // ------------------------------------------------------------------
    // Stage 0: optional input registers (A, B, C and beat flags together)
    // ------------------------------------------------------------------
    logic [A_WIDTH-1:0] a_s;
    logic [B_WIDTH-1:0] b_s;
    logic [C_WIDTH-1:0] c_s;
    logic               v_s;
    logic               clr_s;

    always_comb begin
        a0_d   = A;
        b0_d   = B;
        c0_d   = C;
        v0_d   = in_valid;
        clr0_d = acc_clr;

        a_s    = cfg.in_reg ? a0_q   : A;
        b_s    = cfg.in_reg ? b0_q   : B;
        c_s    = cfg.in_reg ? c0_q   : C;
        v_s    = cfg.in_reg ? v0_q   : in_valid;
        clr_s  = cfg.in_reg ? clr0_q : acc_clr;
    end

    // ------------------------------------------------------------------
    // Stage 1: product. Both operands are extended to the full product
    // width (sign or zero per SIGN_A/SIGN_B); the low P_W bits of that
    // product are the exact signed/unsigned/mixed result, since it always
    // fits in P_W bits.
    // ------------------------------------------------------------------
    logic [P_W-1:0] a_ext;
    logic [P_W-1:0] b_ext;
    logic [P_W-1:0] prod;

    always_comb begin
        a_ext  = {{B_WIDTH{cfg.sign_a & a_s[A_WIDTH-1]}}, a_s};
        b_ext  = {{A_WIDTH{cfg.sign_b & b_s[B_WIDTH-1]}}, b_s};
        prod   = a_ext * b_ext;

        p1_d   = prod;
        c1_d   = c_s;
        v1_d   = v_s;
        clr1_d = clr_s;
    end

    // ------------------------------------------------------------------
    // Stage 2: accumulator add
    // ------------------------------------------------------------------
    logic [C_WIDTH-1:0] p_ext;

    if (C_WIDTH > P_W) begin : g_p_extend
        assign p_ext = {{(C_WIDTH-P_W){signed_mode & p1_q[P_W-1]}}, p1_q};
    end else begin : g_p_direct
        assign p_ext = p1_q;
    end

    // A restart beat (or non-accumulating mode) adds the beat's own C;
    // otherwise the running ACC is the addend.
    logic [C_WIDTH-1:0] addend;
    logic [C_WIDTH-1:0] sum_w;
    logic               sum_ovf;

    assign addend = (cfg.acc && !clr1_q) ? acc_q : c1_q;

    muladd_sat_add #(
        .W (C_WIDTH)
    ) u_sat_add (
        .a_i      (p_ext),
        .b_i      (addend),
        .signed_i (signed_mode),
        .sat_i    (cfg.sat),
        .sum_o    (sum_w),
        .ovf_o    (sum_ovf)
    );

    always_comb begin
        acc_d = acc_q;
        ovf_d = ovf_q;
        v2_d  = v1_q;

        if (v1_q) begin
            acc_d = sum_w;
            // A restart beat clears the sticky flag but still reports
            // its own overflow.
            ovf_d = clr1_q ? sum_ovf : (ovf_q | sum_ovf);
        end else if (clr1_q) begin
            acc_d = '0;
            ovf_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge UserCLK) begin
        if (!clr_n) begin
            a0_q   <= '0;
            b0_q   <= '0;
            c0_q   <= '0;
            v0_q   <= 1'b0;
            clr0_q <= 1'b0;
            p1_q   <= '0;
            c1_q   <= '0;
            v1_q   <= 1'b0;
            clr1_q <= 1'b0;
            acc_q  <= '0;
            v2_q   <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            a0_q   <= a0_d;
            b0_q   <= b0_d;
            c0_q   <= c0_d;
            v0_q   <= v0_d;
            clr0_q <= clr0_d;
            p1_q   <= p1_d;
            c1_q   <= c1_d;
            v1_q   <= v1_d;
            clr1_q <= clr1_d;
            acc_q  <= acc_d;
            v2_q   <= v2_d;
            ovf_q  <= ovf_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign Q         = cfg.accout ? acc_q : sum_w;
    assign out_valid = cfg.accout ? v2_q  : v1_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_muladd_pipe.sv
// ----------------------------------------------------------------------------
// tb_muladd_pipe
//   Directed-vector bench for muladd_pipe. The driver pushes the expected Q
//   and expected arrival cycle of every beat; a monitor pops and compares on
//   every out_valid. Reset state and the sticky overflow flag are checked
//   directly by the driver.
// ----------------------------------------------------------------------------
module tb_muladd_pipe;

    localparam int AW = 8;
    localparam int BW = 8;
    localparam int CW = 20;

    logic          UserCLK = 1'b0;
    logic          clr_n;
    logic [AW-1:0] A;
    logic [BW-1:0] B;
    logic [CW-1:0] C;
    logic          in_valid;
    logic          acc_clr;
    logic [CW-1:0] Q;
    logic          out_valid;
    logic          ovf;
    logic [5:0]    ConfigBits;

    muladd_pipe #(
        .A_WIDTH      (AW),
        .B_WIDTH      (BW),
        .C_WIDTH      (CW),
        .NoConfigBits (6)
    ) dut (
        .UserCLK    (UserCLK),
        .clr_n      (clr_n),
        .A          (A),
        .B          (B),
        .C          (C),
        .in_valid   (in_valid),
        .acc_clr    (acc_clr),
        .Q          (Q),
        .out_valid  (out_valid),
        .ovf        (ovf),
        .ConfigBits (ConfigBits)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 UserCLK = ~UserCLK;

    int cyc = 0;
    always @(posedge UserCLK) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [CW-1:0] exp_q[$];
    int            cyc_q[$];
    int            n_cmp  = 0;
    int            n_err  = 0;
    int            lat    = 1;
    logic          mon_en = 1'b0;

    task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge UserCLK) begin
        if (mon_en && out_valid !== 1'b0) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_out_valid: got out_valid=%b Q=%h expected no beat (t=%0t)",
                         out_valid, Q, $time);
            end else begin
                logic [CW-1:0] e;
                int            ec;
                e  = exp_q.pop_front();
                ec = cyc_q.pop_front();
                n_cmp++;
                if (Q !== e) begin
                    n_err++;
                    $display("FAIL q_value: got %h expected %h (t=%0t)", Q, e, $time);
                end
                n_cmp++;
                if (cyc != ec) begin
                    n_err++;
                    $display("FAIL q_latency: got cycle %0d expected cycle %0d", cyc, ec);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Reset is held for one edge with a live beat on the inputs so that
    // reset must win over it. Configuration changes only happen here.
    task automatic apply_reset(input logic [5:0] cfg);
        clr_n      = 1'b0;
        ConfigBits = cfg;
        A          = 8'hFF;
        B          = 8'hFF;
        C          = 20'hFFFFF;
        in_valid   = 1'b1;
        acc_clr    = 1'b1;
        exp_q.delete();
        cyc_q.delete();
        lat = 1 + int'(cfg[0]) + int'(cfg[5]);
        @(posedge UserCLK);
        #1;
        clr_n    = 1'b1;
        in_valid = 1'b0;
        acc_clr  = 1'b0;
        check("reset_q", Q, '0);
        check_bit("reset_out_valid", out_valid, 1'b0);
        check_bit("reset_ovf", ovf, 1'b0);
        mon_en = 1'b1;
    endtask

    task automatic send(input logic [AW-1:0] a, input logic [BW-1:0] b,
                        input logic [CW-1:0] c, input logic clr,
                        input logic [CW-1:0] exp);
        A        = a;
        B        = b;
        C        = c;
        acc_clr  = clr;
        in_valid = 1'b1;
        exp_q.push_back(exp);
        cyc_q.push_back(cyc + lat);
        @(posedge UserCLK);
        #1;
        in_valid = 1'b0;
        acc_clr  = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        acc_clr  = 1'b0;
        repeat (n) begin
            @(posedge UserCLK);
            #1;
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 20) begin
            @(posedge UserCLK);
            #1;
            t++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: got %0d beats outstanding expected 0", exp_q.size());
            exp_q.delete();
            cyc_q.delete();
        end
        idle(2);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        clr_n      = 1'b0;
        ConfigBits = '0;
        A          = '0;
        B          = '0;
        C          = '0;
        in_valid   = 1'b0;
        acc_clr    = 1'b0;
        @(posedge UserCLK);
        #1;

        // Defaults: 3*5+7, one cycle latency, single out_valid beat.
        apply_reset(6'b000000);
        send(8'd3, 8'd5, 20'd7, 1'b0, 20'd22);
        send(8'd200, 8'd100, 20'd1000, 1'b0, 20'd21000);
        drain();

        // Signed both operands: -2*3+1 = -5, -3*5 = -15.
        apply_reset(6'b000110);
        send(8'hFE, 8'h03, 20'h00001, 1'b0, 20'hFFFFB);
        send(8'h05, 8'hFD, 20'h00000, 1'b0, 20'hFFFF1);
        drain();

        // Mixed sign, A signed only: -1*255 = -255.
        apply_reset(6'b000010);
        send(8'hFF, 8'hFF, 20'h00000, 1'b0, 20'hFFF01);
        drain();

        // Accumulate through ACC, input registered: 3-cycle latency.
        apply_reset(6'b101001);
        send(8'd2, 8'd2, 20'd10, 1'b1, 20'd14);
        send(8'd1, 8'd1, 20'h00055, 1'b0, 20'd15);
        send(8'd1, 8'd1, 20'd0, 1'b0, 20'd16);
        send(8'd1, 8'd1, 20'd0, 1'b0, 20'd17);
        drain();
        idle(3);
        send(8'd1, 8'd1, 20'd0, 1'b0, 20'd18);
        drain();
        // Idle restart beat zeroes ACC without an output beat.
        acc_clr = 1'b1;
        @(posedge UserCLK);
        #1;
        acc_clr = 1'b0;
        idle(3);
        send(8'd1, 8'd1, 20'd0, 1'b0, 20'd1);
        drain();

        // Unsigned saturating accumulate: FFFF0 + FE01 overflows.
        apply_reset(6'b011000);
        send(8'hFF, 8'hFF, 20'hFFFF0, 1'b1, 20'hFFFFF);
        drain();
        check_bit("ovf_sat_set", ovf, 1'b1);
        send(8'h00, 8'h00, 20'h00000, 1'b0, 20'hFFFFF);
        drain();
        check_bit("ovf_sticky", ovf, 1'b1);

        // Same beat wrapping, then a restart beat clears the flag.
        apply_reset(6'b001000);
        send(8'hFF, 8'hFF, 20'hFFFF0, 1'b1, 20'h0FDF1);
        drain();
        check_bit("ovf_wrap_set", ovf, 1'b1);
        send(8'd1, 8'd1, 20'd0, 1'b1, 20'd1);
        drain();
        check_bit("ovf_clr_beat", ovf, 1'b0);

        // Signed saturation at both ends.
        apply_reset(6'b010110);
        send(8'h80, 8'h80, 20'h7FFFF, 1'b0, 20'h7FFFF);
        send(8'h80, 8'h7F, 20'h80000, 1'b0, 20'h80000);
        send(8'h7F, 8'h7F, 20'h00000, 1'b0, 20'h03F01);
        drain();
        check_bit("ovf_signed_sat", ovf, 1'b1);

        // Reset mid-stream: the first two beats are discarded.
        apply_reset(6'b100001);
        send(8'd1, 8'd2, 20'd3, 1'b0, 20'd5);
        send(8'd2, 8'd3, 20'd4, 1'b0, 20'd10);
        apply_reset(6'b100001);
        send(8'd3, 8'd3, 20'd1, 1'b0, 20'd10);
        send(8'd4, 8'd4, 20'd4, 1'b0, 20'd20);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
